qr_givens_scheduler: RTL and testbench

- Sequencing controller for the QR-decomposition datapath.
- Walks the Givens-rotation schedule for an N x N matrix. For each step it issues:
  - one vectoring-mode CORDIC op on the pivot column;
  - then rotation-mode ops on every column to the right of the pivot.
- Tracks in-flight ops against the fixed-latency pipelined CORDIC array and holds off each step until the previous one has fully retired.
- Sits between the top-level start/done control and the CORDIC/matrix-buffer address logic.

---
 rtl/qr_givens_scheduler.sv | 172 +++++++++++++++++
 tb/tb_qr_givens_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_givens_scheduler.sv
// Givens-rotation schedule controller for the QR datapath.
// Walks pivot column c and row pair (r, r-1). For each pair it issues one
// vectoring op, waits for it to retire, then issues rotation ops for every
// column to the right of the pivot and drains them before the next pair.
module qr_givens_scheduler #(
    parameter int N   = 4,
    parameter int CW  = 3,
    parameter int OCW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          op_valid,
    output logic          op_mode,
    output logic [CW-1:0] op_row_hi,
    output logic [CW-1:0] op_row_lo,
    output logic [CW-1:0] op_col,
    input  logic          op_ready,
    input  logic          res_valid,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEC_ISSUE,
        S_VEC_WAIT,
        S_ROT_ISSUE,
        S_DRAIN,
        S_STEP_END,
        S_DONE
    } state_t;

    localparam logic [CW-1:0]  LP_LAST     = CW'(N - 1);
    localparam logic [CW-1:0]  LP_LAST_PIV = CW'(N - 2);
    localparam logic [CW-1:0]  LP_ONE      = CW'(1);
    localparam logic [OCW-1:0] LP_OCW_ONE  = OCW'(1);

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_row;         // upper row of the current pair
    logic [CW-1:0]  r_col;         // pivot column
    logic [CW-1:0]  r_rot;         // rotation column being issued
    logic [OCW-1:0] r_outstanding; // ops accepted by the CORDIC array, not yet retired
    logic           w_xfer;
    logic           w_retire;
    logic           w_more_rows;

    assign w_xfer      = op_valid && op_ready;
    // A result with nothing in flight is a protocol error, not a retirement.
    assign w_retire    = res_valid && (r_outstanding != '0);
    assign w_more_rows = r_row > (r_col + LP_ONE);

    // State register.
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update from the same pre-edge values; blocking assignments
    // here would make the result depend on block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and op/handshake outputs, all decoded from state.
    // NOTE: every output gets a default before the case statement so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        op_valid  = 1'b0;
        op_mode   = 1'b0;
        op_row_hi = '0;
        op_row_lo = '0;
        op_col    = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_VEC_ISSUE;
            end
            S_VEC_ISSUE: begin
                op_valid  = 1'b1;
                op_row_hi = r_row;
                op_row_lo = r_row - LP_ONE;
                op_col    = r_col;
                if (op_ready) w_next = S_VEC_WAIT;
            end
            S_VEC_WAIT: begin
                // The rotation parameters come out of the vectoring result.
                if (r_outstanding == '0) begin
                    w_next = (r_col == LP_LAST) ? S_STEP_END : S_ROT_ISSUE;
                end
            end
            S_ROT_ISSUE: begin
                op_valid  = 1'b1;
                op_mode   = 1'b1;
                op_row_hi = r_row;
                op_row_lo = r_row - LP_ONE;
                op_col    = r_rot;
                if (op_ready && (r_rot == LP_LAST)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // The next pair shares a row with this one, so it must be written back.
                if (r_outstanding == '0) w_next = S_STEP_END;
            end
            S_STEP_END: begin
                if (!w_more_rows && (r_col == LP_LAST_PIV)) w_next = S_DONE;
                else                                        w_next = S_VEC_ISSUE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Schedule indices: pivot/row walk and rotation column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
            r_rot <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col <= '0;
                        r_row <= LP_LAST;
                    end
                end
                S_VEC_WAIT: begin
                    if (w_next == S_ROT_ISSUE) r_rot <= r_col + LP_ONE;
                end
                S_ROT_ISSUE: begin
                    if (w_xfer && (r_rot != LP_LAST)) r_rot <= r_rot + LP_ONE;
                end
                S_STEP_END: begin
                    if (w_more_rows) begin
                        r_row <= r_row - LP_ONE;
                    end else begin
                        r_col <= r_col + LP_ONE;
                        r_row <= LP_LAST;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // In-flight op counter and sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            err           <= 1'b0;
        end else begin
            if (res_valid && (r_outstanding == '0)) err <= 1'b1;
            case ({w_xfer, w_retire})
                2'b10:   r_outstanding <= r_outstanding + LP_OCW_ONE;
                2'b01:   r_outstanding <= r_outstanding - LP_OCW_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_qr_givens_scheduler.sv
// Self-checking bench for qr_givens_scheduler (N = 4).
// A 9-cycle CORDIC latency model returns one result per accepted op.
// Expected ops are queued at start and popped on each transfer.
module tb_qr_givens_scheduler;

    localparam int N       = 4;
    localparam int CW      = 3;
    localparam int OCW     = 4;
    localparam int LAT     = 9;
    localparam int BUDGET  = 1000;
    localparam int EXP_OPS = 20;
    localparam int EXP_VEC = 6;
    localparam int EXP_ROT = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op_ready;
    logic          spur;
    logic          res_valid;
    logic          busy;
    logic          done;
    logic          op_valid;
    logic          op_mode;
    logic [CW-1:0] op_row_hi;
    logic [CW-1:0] op_row_lo;
    logic [CW-1:0] op_col;
    logic          err;

    qr_givens_scheduler #(.N(N), .CW(CW), .OCW(OCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .op_valid  (op_valid),
        .op_mode   (op_mode),
        .op_row_hi (op_row_hi),
        .op_row_lo (op_row_lo),
        .op_col    (op_col),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Fixed-latency CORDIC array: each accepted op retires LAT cycles later.
    logic [LAT-1:0] r_pipe;
    always @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[LAT-2:0], op_valid && op_ready};
    end
    assign res_valid = r_pipe[LAT-1] | spur;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  sb[$];
    int          xfer_total = 0;
    int          vec_total  = 0;
    int          rot_total  = 0;
    int          done_total = 0;
    int          tb_out     = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_f     = '0;
    logic        last_mode  = 1'b1;
    int          b_x, b_v, b_r, b_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference schedule, pushed when a run is started.
    task automatic push_schedule();
        for (int c = 0; c <= N - 2; c++) begin
            for (int r = N - 1; r >= c + 1; r--) begin
                sb.push_back({1'b0, 3'(r), 3'(r - 1), 3'(c)});
                for (int k = c + 1; k <= N - 1; k++) begin
                    sb.push_back({1'b1, 3'(r), 3'(r - 1), 3'(k)});
                end
            end
        end
    endtask

    // Per-cycle observation, sampled at the falling edge.
    task automatic monitor();
        logic [9:0] f;
        logic [9:0] e;
        f = {op_mode, op_row_hi, op_row_lo, op_col};
        if (prev_stall) begin
            check("hold_valid", 32'(op_valid), 1);
            check("hold_fields", 32'(f), 32'(prev_f));
        end
        // First op of a step phase must wait for all earlier ops to retire.
        if (op_valid && (!op_mode || !last_mode)) check("issue_with_outstanding", 32'(tb_out), 0);
        if (op_valid && op_ready) begin
            xfer_total++;
            if (op_mode) rot_total++;
            else         vec_total++;
            last_mode = op_mode;
            if (sb.size() == 0) begin
                check("unexpected_op", 32'(f), 32'h3ff);
            end else begin
                e = sb.pop_front();
                check("op_fields", 32'(f), 32'(e));
            end
        end
        if (done) done_total++;
        if ((op_valid && op_ready) && !res_valid) tb_out++;
        else if (!(op_valid && op_ready) && res_valid && tb_out > 0) tb_out--;
        else if ((op_valid && op_ready) && res_valid && tb_out == 0) tb_out++;
        prev_stall = op_valid && !op_ready;
        prev_f     = f;
    endtask

    // Advance one clock; returns #1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        push_schedule();
        b_x = xfer_total;
        b_v = vec_total;
        b_r = rot_total;
        b_d = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("valid_after_start", 32'(op_valid), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_total == b_d && n < BUDGET) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(n < BUDGET), 1);
    endtask

    task automatic end_of_run(input string tag);
        repeat (3) tick();
        check({tag, "_xfers"}, 32'(xfer_total - b_x), EXP_OPS);
        check({tag, "_vec"}, 32'(vec_total - b_v), EXP_VEC);
        check({tag, "_rot"}, 32'(rot_total - b_r), EXP_ROT);
        check({tag, "_done_pulses"}, 32'(done_total - b_d), 1);
        check({tag, "_sb_left"}, 32'(sb.size()), 0);
        check({tag, "_busy_idle"}, 32'(busy), 0);
        check({tag, "_valid_idle"}, 32'(op_valid), 0);
        check({tag, "_retired"}, 32'(tb_out), 0);
    endtask

    initial begin
        int n;
        int x0;
        rst      = 1'b1;
        start    = 1'b0;
        op_ready = 1'b1;
        spur     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(op_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Run 1: nominal decomposition.
        do_start();
        check("first_op", 32'({op_mode, op_row_hi, op_row_lo, op_col}), 32'({1'b0, 3'd3, 3'd2, 3'd0}));
        wait_done();
        end_of_run("run1");
        check("run1_err", 32'(err), 0);

        // Run 2: op_ready low for 3 cycles while rotation col 2 is presented.
        do_start();
        n = 0;
        while (!(op_valid && op_mode && op_col == 3'd2) && n < BUDGET) begin
            tick();
            n++;
        end
        check("stall_find_timeout", 32'(n < BUDGET), 1);
        op_ready = 1'b0;
        x0 = xfer_total;
        repeat (3) tick();
        check("stall_no_xfer", 32'(xfer_total - x0), 0);
        check("stall_col", 32'(op_col), 2);
        check("stall_mode", 32'(op_mode), 1);
        op_ready = 1'b1;
        wait_done();
        end_of_run("run2");

        // Run 3: reset after the 7th transfer.
        do_start();
        n = 0;
        while ((xfer_total - b_x) < 7 && n < BUDGET) begin
            tick();
            n++;
        end
        check("reset_wait_timeout", 32'(n < BUDGET), 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              32'({busy, done, op_valid, op_mode, op_row_hi, op_row_lo, op_col, err}), 0);
        sb.delete();
        tb_out     = 0;
        prev_stall = 1'b0;
        last_mode  = 1'b1;
        x0 = done_total;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) tick();
        check("midrst_no_done", 32'(done_total - x0), 0);

        // Run 4: fresh run after reset reproduces the full sequence.
        do_start();
        check("rerun_first_op", 32'({op_mode, op_row_hi, op_row_lo, op_col}), 32'({1'b0, 3'd3, 3'd2, 3'd0}));
        wait_done();
        end_of_run("run4");
        check("run4_err", 32'(err), 0);

        // Spurious result while idle sets the sticky error.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_err", 32'(err), 1);
        check("spur_busy", 32'(busy), 0);
        do_start();
        wait_done();
        end_of_run("run5");
        check("run5_err_sticky", 32'(err), 1);

        // Run 6: start pulses mid-run and in the done cycle are ignored.
        do_start();
        n = 0;
        while ((xfer_total - b_x) < 5 && n < BUDGET) begin
            tick();
            n++;
        end
        check("midstart_wait_timeout", 32'(n < BUDGET), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < BUDGET) begin
            tick();
            n++;
        end
        check("donecycle_wait_timeout", 32'(n < BUDGET), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        end_of_run("run6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
